// File: rtl/decode_ctrl_stage.sv
// Registered decode stage for the 16-bit ISA: flag register, B/BR resolution, flag-hazard stall, ID/EX register.
// Optional macro DECODE_FLAG_FWD_EN forwards EX flag writes into branch conditions and removes the hazard stall.
module decode_ctrl_stage #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             in_valid,
  input  logic [PC_W-1:0]  pc_plus2,
  input  logic [PC_W-1:0]  rs_data,
  input  logic             ex_stall,
  input  logic             id_flush,
  input  logic [2:0]       ex_flag_we,
  input  logic [2:0]       ex_flags,
  output logic             id_stall,
  output logic             branch_taken,
  output logic [PC_W-1:0]  branch_target,
  output logic [2:0]       flags,
  output logic             halted,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic             idex_valid,
  output logic [3:0]       idex_src1,
  output logic [3:0]       idex_src2,
  output logic [3:0]       idex_dst,
  output logic             idex_regwrite,
  output logic             idex_alusrc1,
  output logic             idex_alusrc2,
  output logic             idex_memread,
  output logic             idex_memwrite,
  output logic             idex_memtoreg,
  output logic             idex_pctoreg,
  output logic [3:0]       idex_aluop,
  output logic [1:0]       idex_imdchoice,
  output logic [2:0]       idex_flag_en
);

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int FZ = 2;
  localparam int FV = 1;
  localparam int FN = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dst;
    logic       regwrite;
    logic       alusrc1;
    logic       alusrc2;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       pctoreg;
    logic [3:0] aluop;
    logic [1:0] imdchoice;
    logic [2:0] flag_en;
  } idex_t;

  idex_t            idex_q, idex_d, dec;
  logic [2:0]       flags_q, flags_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;

  logic [3:0]      opcode;
  logic [2:0]      ccc;
  logic            is_b, is_br, is_branch, is_hlt;
  logic [2:0]      eff_flags;
  logic            cond;
  logic            haz;
  logic            stall_int;
  logic [PC_W-1:0] b_off;
  logic [PC_W-1:0] target_int;

  assign opcode    = instr[15:12];
  assign ccc       = instr[11:9];
  assign is_b      = (opcode == OP_B);
  assign is_br     = (opcode == OP_BR);
  assign is_branch = is_b | is_br;
  assign is_hlt    = (opcode == OP_HLT);

  // alusrc1 selects PC as ALU operand A, alusrc2 selects the immediate as operand B.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.dst   = instr[11:8];
    dec.src1  = instr[7:4];
    dec.src2  = instr[3:0];
    dec.aluop = opcode;
    case (opcode)
      OP_ADD, OP_SUB: begin
        dec.regwrite = 1'b1;
        dec.flag_en  = 3'b111;
      end
      OP_XOR: begin
        dec.regwrite = 1'b1;
        dec.flag_en  = 3'b100;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        dec.regwrite     = 1'b1;
        dec.alusrc2      = 1'b1;
        dec.imdchoice[0] = 1'b1;
        dec.flag_en      = 3'b100;
      end
      OP_RED, OP_PADDSB: dec.regwrite = 1'b1;
      OP_LW: begin
        dec.regwrite  = 1'b1;
        dec.memread   = 1'b1;
        dec.memtoreg  = 1'b1;
        dec.alusrc2   = 1'b1;
        dec.imdchoice = 2'b01;
        dec.aluop     = OP_ADD;
      end
      OP_SW: begin
        dec.memwrite  = 1'b1;
        dec.alusrc2   = 1'b1;
        dec.imdchoice = 2'b01;
        dec.src2      = instr[11:8];
        dec.aluop     = OP_ADD;
      end
      OP_LLB, OP_LHB: begin
        dec.regwrite  = 1'b1;
        dec.alusrc2   = 1'b1;
        dec.imdchoice = 2'b11;
        dec.src1      = instr[11:8];
      end
      OP_B: begin
        dec.alusrc1 = 1'b1;
        dec.alusrc2 = 1'b1;
        dec.aluop   = OP_ADD;
      end
      OP_BR: begin
        dec.alusrc1 = 1'b1;
        dec.aluop   = OP_ADD;
      end
      OP_PCS: begin
        dec.regwrite = 1'b1;
        dec.pctoreg  = 1'b1;
        dec.alusrc1  = 1'b1;
        dec.aluop    = OP_ADD;
      end
      default: begin
        dec       = '0;
        dec.valid = 1'b1;
      end
    endcase
  end

`ifdef DECODE_FLAG_FWD_EN
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      eff_flags[i] = ex_flag_we[i] ? ex_flags[i] : flags_q[i];
    end
  end
  assign haz = 1'b0;
`else
  assign eff_flags = flags_q;
  // A branch may not read flags that the instruction now in EX is still producing.
  assign haz = in_valid & is_branch & (ccc != 3'b111) & idex_q.valid & (|idex_q.flag_en) & ~halted_q;
`endif

  always_comb begin
    cond = 1'b1;
    case (ccc)
      3'b000:  cond = ~eff_flags[FZ];
      3'b001:  cond = eff_flags[FZ];
      3'b010:  cond = ~eff_flags[FZ] & ~eff_flags[FN];
      3'b011:  cond = eff_flags[FN];
      3'b100:  cond = eff_flags[FZ] | ~eff_flags[FN];
      3'b101:  cond = eff_flags[FN] | eff_flags[FZ];
      3'b110:  cond = eff_flags[FV];
      default: cond = 1'b1;
    endcase
  end

  assign stall_int = haz | ex_stall;
  assign b_off     = {{(PC_W-10){instr[8]}}, instr[8:0], 1'b0};

  always_comb begin
    target_int = pc_plus2;
    if (is_b) begin
      target_int = pc_plus2 + b_off;
    end else if (is_br) begin
      target_int = rs_data;
    end
  end

  assign id_stall      = ~rst & stall_int;
  assign branch_taken  = ~rst & in_valid & ~halted_q & ~id_flush & ~stall_int & is_branch & cond;
  assign branch_target = rst ? '0 : target_int;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      flags_d[i] = ex_flag_we[i] ? ex_flags[i] : flags_q[i];
    end
    halted_d     = halted_q | (is_hlt & in_valid & ~id_flush & ~stall_int);
    hazard_cnt_d = hazard_cnt_q;
    if (haz && (hazard_cnt_q != {CNT_W{1'b1}})) begin
      hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
    end
    idex_d = idex_q;
    if (!ex_stall) begin
      if (id_flush || stall_int || !in_valid || halted_q) begin
        idex_d = '0;
      end else begin
        idex_d = dec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q      <= '0;
      halted_q     <= 1'b0;
      hazard_cnt_q <= '0;
      idex_q       <= '0;
    end else begin
      flags_q      <= flags_d;
      halted_q     <= halted_d;
      hazard_cnt_q <= hazard_cnt_d;
      idex_q       <= idex_d;
    end
  end

  assign flags          = flags_q;
  assign halted         = halted_q;
  assign hazard_cnt     = hazard_cnt_q;
  assign idex_valid     = idex_q.valid;
  assign idex_src1      = idex_q.src1;
  assign idex_src2      = idex_q.src2;
  assign idex_dst       = idex_q.dst;
  assign idex_regwrite  = idex_q.regwrite;
  assign idex_alusrc1   = idex_q.alusrc1;
  assign idex_alusrc2   = idex_q.alusrc2;
  assign idex_memread   = idex_q.memread;
  assign idex_memwrite  = idex_q.memwrite;
  assign idex_memtoreg  = idex_q.memtoreg;
  assign idex_pctoreg   = idex_q.pctoreg;
  assign idex_aluop     = idex_q.aluop;
  assign idex_imdchoice = idex_q.imdchoice;
  assign idex_flag_en   = idex_q.flag_en;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: directed scenarios then random traffic against an opcode-table reference model.
module tb_decode_ctrl_stage;

  localparam int PC_W  = 16;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef DECODE_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      instr;
  logic             in_valid;
  logic [PC_W-1:0]  pc_plus2;
  logic [PC_W-1:0]  rs_data;
  logic             ex_stall;
  logic             id_flush;
  logic [2:0]       ex_flag_we;
  logic [2:0]       ex_flags;
  logic             id_stall;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_target;
  logic [2:0]       flags;
  logic             halted;
  logic [CNT_W-1:0] hazard_cnt;
  logic             idex_valid;
  logic [3:0]       idex_src1, idex_src2, idex_dst;
  logic             idex_regwrite, idex_alusrc1, idex_alusrc2, idex_memread;
  logic             idex_memwrite, idex_memtoreg, idex_pctoreg;
  logic [3:0]       idex_aluop;
  logic [1:0]       idex_imdchoice;
  logic [2:0]       idex_flag_en;

  decode_ctrl_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .pc_plus2(pc_plus2),
    .rs_data(rs_data), .ex_stall(ex_stall), .id_flush(id_flush), .ex_flag_we(ex_flag_we),
    .ex_flags(ex_flags), .id_stall(id_stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .flags(flags), .halted(halted), .hazard_cnt(hazard_cnt),
    .idex_valid(idex_valid), .idex_src1(idex_src1), .idex_src2(idex_src2), .idex_dst(idex_dst),
    .idex_regwrite(idex_regwrite), .idex_alusrc1(idex_alusrc1), .idex_alusrc2(idex_alusrc2),
    .idex_memread(idex_memread), .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg),
    .idex_pctoreg(idex_pctoreg), .idex_aluop(idex_aluop), .idex_imdchoice(idex_imdchoice),
    .idex_flag_en(idex_flag_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] s1, s2, d;
    logic       rw, a1, a2, mr, mw, m2r, p2r;
    logic [3:0] op;
    logic [1:0] imd;
    logic [2:0] fe;
  } idex_t;

  idex_t       m_idex, n_idex, o_idex;
  logic [2:0]  m_flags, n_flags;
  logic        m_halted, n_halted;
  int          m_cnt, n_cnt;
  logic        e_haz, e_stall, e_taken;
  logic [15:0] e_target;
  logic        last_stall, last_taken;
  logic [15:0] last_target;
  logic [15:0] ri;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode as set membership per opcode.
  function automatic idex_t ref_decode(input logic [15:0] ins);
    idex_t r;
    logic [3:0] op;
    op = ins[15:12];
    r = '0;
    r.v = 1'b1;
    if (op == 4'hF) return r;
    r.d   = ins[11:8];
    r.s1  = (op inside {4'hA, 4'hB}) ? ins[11:8] : ins[7:4];
    r.s2  = (op == 4'h9) ? ins[11:8] : ins[3:0];
    r.rw  = !(op inside {4'h9, 4'hC, 4'hD});
    r.a1  = op inside {4'hC, 4'hD, 4'hE};
    r.a2  = op inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    r.mr  = (op == 4'h8);
    r.mw  = (op == 4'h9);
    r.m2r = (op == 4'h8);
    r.p2r = (op == 4'hE);
    r.op  = (op inside {4'h8, 4'h9, 4'hC, 4'hD, 4'hE}) ? 4'h0 : op;
    r.imd = {op inside {4'hA, 4'hB}, op inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}};
    r.fe  = (op inside {4'h0, 4'h1}) ? 3'b111 : (op inside {4'h2, 4'h4, 4'h5, 4'h6}) ? 3'b100 : 3'b000;
    return r;
  endfunction

  task automatic mreset();
    m_idex = '0; m_flags = '0; m_halted = 1'b0; m_cnt = 0;
  endtask

  task automatic comb_model();
    logic [3:0] op;
    logic [2:0] ef;
    logic       isbr, c, z, v, n;
    int         off;
    op   = instr[15:12];
    isbr = (op == 4'hC) || (op == 4'hD);
    for (int i = 0; i < 3; i++) ef[i] = (FWD && ex_flag_we[i]) ? ex_flags[i] : m_flags[i];
    z = ef[2]; v = ef[1]; n = ef[0];
    case (instr[11:9])
      3'd0: c = !z;
      3'd1: c = z;
      3'd2: c = !z && !n;
      3'd3: c = n;
      3'd4: c = z || !n;
      3'd5: c = n || z;
      3'd6: c = v;
      default: c = 1'b1;
    endcase
    e_haz   = !FWD && in_valid && isbr && (instr[11:9] != 3'd7) && m_idex.v && (m_idex.fe != 3'b000) && !m_halted;
    e_stall = e_haz || ex_stall;
    e_taken = in_valid && !m_halted && !id_flush && !e_stall && isbr && c;
    off = int'(instr[8:0]);
    if (instr[8]) off = off - 512;
    if (op == 4'hC) e_target = 16'(int'(pc_plus2) + 2 * off);
    else if (op == 4'hD) e_target = rs_data;
    else e_target = pc_plus2;
    if (rst) begin
      e_haz = 1'b0; e_stall = 1'b0; e_taken = 1'b0; e_target = '0;
    end
  endtask

  task automatic next_model();
    for (int i = 0; i < 3; i++) n_flags[i] = ex_flag_we[i] ? ex_flags[i] : m_flags[i];
    if (ex_stall) n_idex = m_idex;
    else if (id_flush || e_stall || !in_valid || m_halted) n_idex = '0;
    else n_idex = ref_decode(instr);
    n_halted = m_halted || (in_valid && instr[15:12] == 4'hF && !id_flush && !e_stall);
    n_cnt = (e_haz && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
  endtask

  task automatic check_regs();
    o_idex = '{idex_valid, idex_src1, idex_src2, idex_dst, idex_regwrite, idex_alusrc1, idex_alusrc2,
               idex_memread, idex_memwrite, idex_memtoreg, idex_pctoreg, idex_aluop, idex_imdchoice,
               idex_flag_en};
    chk("flags", 64'(flags), 64'(m_flags));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("hazard_cnt", 64'(hazard_cnt), 64'(m_cnt));
    chk("idex", 64'(o_idex), 64'(m_idex));
  endtask

  // One clock: combinational check mid-low-phase, registered check just after the rising edge.
  task automatic cycle();
    #1;
    if (rst) mreset();
    comb_model();
    last_stall = id_stall; last_taken = branch_taken; last_target = branch_target;
    chk("id_stall", 64'(id_stall), 64'(e_stall));
    chk("branch_taken", 64'(branch_taken), 64'(e_taken));
    chk("branch_target", 64'(branch_target), 64'(e_target));
    check_regs();
    next_model();
    @(posedge clk);
    #1;
    if (!rst) begin
      m_idex = n_idex; m_flags = n_flags; m_halted = n_halted; m_cnt = n_cnt;
    end
    check_regs();
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] i_instr, input logic v, input logic f, input logic s,
                       input logic [2:0] we, input logic [2:0] fl, input logic [15:0] pc,
                       input logic [15:0] rs);
    instr = i_instr; in_valid = v; id_flush = f; ex_stall = s;
    ex_flag_we = we; ex_flags = fl; pc_plus2 = pc; rs_data = rs;
    cycle();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    mreset();
    rst = 1'b1;
    instr = 16'hC3FF; in_valid = 1'b1; id_flush = 1'b0; ex_stall = 1'b1;
    ex_flag_we = 3'b111; ex_flags = 3'b111; pc_plus2 = 16'h4442; rs_data = 16'h9999;
    @(negedge clk);
    cycle();
    chk("rst_id_stall", 64'(last_stall), 64'd0);
    chk("rst_target", 64'(last_target), 64'd0);
    cycle();
    rst = 1'b0;

    drive(16'h0123, 1, 0, 0, 3'b000, 3'b000, 16'h0010, 16'h0000);
    chk("t1_valid", 64'(idex_valid), 64'd1);
    chk("t1_dst", 64'(idex_dst), 64'd1);
    chk("t1_src1", 64'(idex_src1), 64'd2);
    chk("t1_src2", 64'(idex_src2), 64'd3);
    chk("t1_aluop", 64'(idex_aluop), 64'd0);
    chk("t1_regwrite", 64'(idex_regwrite), 64'd1);
    chk("t1_flag_en", 64'(idex_flag_en), 64'd7);

    drive(16'h1456, 1, 0, 0, 3'b000, 3'b000, 16'h0012, 16'h0000);
    drive(16'hC205, 1, 0, 0, 3'b100, 3'b100, 16'h0100, 16'h0000);
`ifdef DECODE_FLAG_FWD_EN
    chk("t3_stall", 64'(last_stall), 64'd0);
    chk("t3_taken", 64'(last_taken), 64'd1);
    chk("t3_target", 64'(last_target), 64'h010A);
    chk("t3_cnt", 64'(hazard_cnt), 64'd0);
`else
    chk("t2_stall", 64'(last_stall), 64'd1);
    chk("t2_cnt", 64'(hazard_cnt), 64'd1);
    drive(16'hC205, 1, 0, 0, 3'b000, 3'b000, 16'h0100, 16'h0000);
    chk("t2_taken", 64'(last_taken), 64'd1);
    chk("t2_target", 64'(last_target), 64'h010A);
    chk("t2_cnt_hold", 64'(hazard_cnt), 64'd1);
`endif

    drive(16'h0123, 1, 0, 0, 3'b000, 3'b000, 16'h0200, 16'h0000);
    drive(16'hDE00, 1, 0, 0, 3'b000, 3'b000, 16'h0202, 16'h1234);
    chk("t4_stall", 64'(last_stall), 64'd0);
    chk("t4_taken", 64'(last_taken), 64'd1);
    chk("t4_target", 64'(last_target), 64'h1234);

    drive(16'hF000, 1, 0, 0, 3'b000, 3'b000, 16'h0300, 16'h0000);
    chk("t5_halted", 64'(halted), 64'd1);
    drive(16'h0123, 1, 0, 0, 3'b000, 3'b000, 16'h0302, 16'h0000);
    chk("t5_bubble", 64'(idex_valid), 64'd0);
    drive(16'hC000, 1, 0, 0, 3'b000, 3'b000, 16'h0304, 16'h0000);
    chk("t5_no_branch", 64'(last_taken), 64'd0);
    reset_pulse();
    drive(16'hF000, 1, 1, 0, 3'b000, 3'b000, 16'h0300, 16'h0000);
    chk("t5_flush_halt", 64'(halted), 64'd0);

    drive(16'h0123, 1, 0, 0, 3'b000, 3'b000, 16'h0400, 16'h0000);
    drive(16'h2456, 1, 0, 1, 3'b000, 3'b000, 16'h0402, 16'h0000);
    chk("t6_hold_dst", 64'(idex_dst), 64'd1);
    chk("t6_stall", 64'(last_stall), 64'd1);
    rst = 1'b1;
    cycle();
    chk("t6_rst_valid", 64'(idex_valid), 64'd0);
    chk("t6_rst_stall", 64'(last_stall), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0 || (m_halted && $urandom_range(0, 5) == 0)) begin
        reset_pulse();
      end
      ri = 16'($urandom);
      if (ri[15:12] == 4'hF && $urandom_range(0, 7) != 0) ri[15:12] = 4'h0;
      if ($urandom_range(0, 2) == 0) ri[15:12] = ($urandom_range(0, 1) == 1) ? 4'hC : 4'hD;
      drive(ri, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
            3'($urandom), 3'($urandom), 16'({$urandom, 1'b0}), 16'($urandom));
    end

    reset_pulse();
    drive(16'h0123, 1, 0, 0, 3'b000, 3'b000, 16'h0500, 16'h0000);
    for (int k = 0; k < 260; k++) begin
      drive(16'hC010, 1, 0, 1, 3'b000, 3'b000, 16'h0502, 16'h0000);
    end
    chk("sat_cnt", 64'(hazard_cnt), FWD ? 64'd0 : 64'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
